// File: rtl/xor_descrambler_64.sv
// xor_descrambler_64
//   Receive-side descrambler for the 64-bit additive XOR scrambling path.
//   Each accepted scrambled word is XORed with the current LFSR keystream
//   value. The LFSR then steps once, and the plaintext is registered into a
//   single valid/ready output stage.
//
//   Ports
//     clk        rising-edge clock
//     reset_n    asynchronous active-low reset
//     seed_load  load seed_val into the LFSR (a zero seed maps to DEFAULT_SEED)
//     seed_val   new LFSR seed
//     in_valid   scrambled word available
//     in_data    scrambled word
//     in_ready   word accepted this cycle when in_valid is also high
//     out_valid  output register holds a word
//     out_data   descrambled word
//     out_ready  consumer takes out_data this cycle
//     word_cnt   words accepted since reset or the last seed load
//     out_par    (XDESCR_PARITY_EN) even parity of out_data[62:0]
//     par_err    (XDESCR_PARITY_EN) out_valid and parity disagrees with bit 63
//
//   Build option: define XDESCR_PARITY_EN to add the out_par/par_err outputs.
module xor_descrambler_64 #(
    parameter logic [63:0] DEFAULT_SEED = 64'h0000_0000_0000_0001,
    parameter int          CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             seed_load,
    input  logic [63:0]      seed_val,
    input  logic             in_valid,
    input  logic [63:0]      in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [63:0]      out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] word_cnt
`ifdef XDESCR_PARITY_EN
    ,
    output logic             out_par,
    output logic             par_err
`endif
);

    typedef enum logic {SEEDED, LOADING} state_t;

    state_t      state;
    logic [63:0] lfsr;
    logic [63:0] lfsr_next;
    logic [63:0] plain;
    logic        fb;
    logic        accept;

    // The cycle that carries seed_load and the cycle after it both block
    // input. This keeps every word on one keystream. The output stage can
    // still drain during those cycles.
    assign in_ready  = (state == SEEDED) & ~seed_load & (~out_valid | out_ready);
    assign accept    = in_valid & in_ready;

    // Fibonacci LFSR with taps 64,63,61,60
    assign fb        = lfsr[63] ^ lfsr[62] ^ lfsr[60] ^ lfsr[59];
    assign lfsr_next = {lfsr[62:0], fb};
    assign plain     = in_data ^ lfsr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= SEEDED;
            lfsr      <= DEFAULT_SEED;
            word_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state <= (state == SEEDED && seed_load) ? LOADING : SEEDED;

            // A load takes priority. in_ready is low, so no accept can collide.
            if (seed_load) begin
                lfsr     <= (seed_val == 64'h0) ? DEFAULT_SEED : seed_val;
                word_cnt <= '0;
            end else if (accept) begin
                lfsr     <= lfsr_next;
                word_cnt <= word_cnt + CNT_W'(1);
            end

            if (accept) begin
                out_data  <= plain;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef XDESCR_PARITY_EN
    logic plain_par;
    assign plain_par = ^plain[62:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_par <= 1'b0;
            par_err <= 1'b0;
        end else if (accept) begin
            out_par <= plain_par;
            par_err <= plain_par ^ plain[63];
        end else if (out_ready) begin
            // par_err is qualified by out_valid, so it drops with it.
            par_err <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_xor_descrambler_64.sv
module tb_xor_descrambler_64;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        seed_load;
    logic [63:0] seed_val;
    logic        in_valid;
    logic [63:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_data;
    logic        out_ready;
    logic [31:0] word_cnt;
`ifdef XDESCR_PARITY_EN
    logic        out_par;
    logic        par_err;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    xor_descrambler_64 dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .seed_load (seed_load),
        .seed_val  (seed_val),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .word_cnt  (word_cnt)
`ifdef XDESCR_PARITY_EN
        ,
        .out_par   (out_par),
        .par_err   (par_err)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] step(input logic [63:0] s);
        return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
    endfunction

    logic [63:0] ks, pt, held;

    initial begin
        reset_n   = 1'b0;
        seed_load = 1'b0;
        seed_val  = 64'h0;
        in_valid  = 1'b0;
        in_data   = 64'h0;
        out_ready = 1'b1;

        // reset state
        #3;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'h0);
        chk("rst_word_cnt", 64'(word_cnt), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        #1 chk("rst_in_ready", 64'(in_ready), 64'd1);

        // zero words expose the raw keystream: 1, 2
        in_valid = 1'b1;
        in_data  = 64'h0;
        tick();
        chk("ks0_data", out_data, 64'h1);
        chk("ks0_valid", 64'(out_valid), 64'd1);
        tick();
        chk("ks1_data", out_data, 64'h2);
        chk("ks1_cnt", 64'(word_cnt), 64'd2);
        in_valid = 1'b0;
        tick();
        chk("drain_valid", 64'(out_valid), 64'd0);

        // all-ones word after a fresh reset
        reset_n = 1'b0;
        #1 reset_n = 1'b1;
        in_valid = 1'b1;
        in_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        chk("ones_data", out_data, 64'hFFFF_FFFF_FFFF_FFFE);
        in_valid = 1'b0;
        tick();

        // zero-seed load with a word pending: the load wins
        seed_load = 1'b1;
        seed_val  = 64'h0;
        in_valid  = 1'b1;
        in_data   = 64'h0;
        #1 chk("load_in_ready", 64'(in_ready), 64'd0);
        tick();
        seed_load = 1'b0;
        chk("load_cnt", 64'(word_cnt), 64'd0);
        chk("load_no_accept", 64'(out_valid), 64'd0);
        #1 chk("loading_in_ready", 64'(in_ready), 64'd0);
        tick();
        chk("seeded_in_ready", 64'(in_ready), 64'd1);
        tick();
        chk("zseed_data", out_data, 64'h1);
        chk("zseed_cnt", 64'(word_cnt), 64'd1);
        in_valid = 1'b0;
        tick();

        // backpressure: keystream is now 2
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h0123_4567_89AB_CDEF;
        tick();
        chk("bp_data", out_data, 64'h0123_4567_89AB_CDED);
        held = out_data;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_stable", out_data, 64'h0123_4567_89AB_CDED);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_cnt", 64'(word_cnt), 64'd2);
        end
        out_ready = 1'b1;
        in_data   = 64'h0;
        #1 chk("bp_release_ready", 64'(in_ready), 64'd1);
        tick();
        chk("bp_r0_data", out_data, 64'h4);
        chk("bp_r0_cnt", 64'(word_cnt), 64'd3);
        tick();
        chk("bp_r1_data", out_data, 64'h8);
        chk("bp_r1_cnt", 64'(word_cnt), 64'd4);
        tick();
        chk("bp_r2_data", out_data, 64'h10);
        chk("bp_r2_cnt", 64'(word_cnt), 64'd5);
        in_valid = 1'b0;
        tick();

        // loopback against a transmit-side scrambler model
        seed_load = 1'b1;
        seed_val  = 64'hDEAD_BEEF_0BAD_F00D;
        tick();
        seed_load = 1'b0;
        tick();
        ks = 64'hDEAD_BEEF_0BAD_F00D;
        for (int i = 0; i < 1000; i++) begin
            pt        = {$urandom, $urandom};
            pt[63]    = ^pt[62:0];
            in_data   = pt ^ ks;
            in_valid  = 1'b1;
            ks        = step(ks);
            tick();
            chk("loop_data", out_data, pt);
`ifdef XDESCR_PARITY_EN
            chk("loop_par", 64'(out_par), 64'(pt[63]));
            chk("loop_par_err", 64'(par_err), 64'd0);
`endif
        end
        chk("loop_cnt", 64'(word_cnt), 64'd1000);

        // reset mid-stream with a word held
        in_valid = 1'b0;
        chk("mid_valid_pre", 64'(out_valid), 64'd1);
        #2 reset_n = 1'b0;
        #1 chk("mid_rst_valid", 64'(out_valid), 64'd0);
        reset_n  = 1'b1;
        in_valid = 1'b1;
        in_data  = 64'h0;
        tick();
        chk("mid_rst_ks", out_data, 64'h1);
        in_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
